// File: rtl/espic_arbiter_n_if.sv
// Handshake bundle between the ESPIC-N arbiter and its node-side driver.
// The arbiter uses the slave modport; whatever drives nodes and ext_signal uses master.
interface espic_arbiter_n_if #(
  parameter int N_NODES = 2,
  parameter int OP_W    = 16
);
  logic                      ext_signal;
  logic [N_NODES*OP_W-1:0]   in_op_node;
  logic [N_NODES-1:0]        op_valid;
  logic                      out_node_IRQ0;
  logic [N_NODES-1:0]        out_mutex_IRQ1;
  logic [N_NODES-1:0]        out_IRQ2;
  logic                      ext_overrun;

  modport master (
    output ext_signal, in_op_node, op_valid,
    input  out_node_IRQ0, out_mutex_IRQ1, out_IRQ2, ext_overrun
  );

  modport slave (
    input  ext_signal, in_op_node, op_valid,
    output out_node_IRQ0, out_mutex_IRQ1, out_IRQ2, ext_overrun
  );
endinterface

// File: rtl/espic_arbiter_n.sv
// ESPIC-N interrupt arbiter: periodic tick (IRQ0), priority-arbitrated ext grant (IRQ1)
// and per-node raised pulses (IRQ2), all driven from node opcodes.
module espic_arbiter_n #(
  parameter int N_NODES     = 2,
  parameter int OP_W        = 16,
  parameter int PRIO_W      = 4,
  parameter int PRIO_RST    = 1,
  parameter int PULSE_LEN   = 1000,
  parameter int TICK_PERIOD = 50_000_000,
  parameter int TICK_HIGH   = 50_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  espic_arbiter_n_if.slave   bus
);
  localparam int TICK_W  = $clog2(TICK_PERIOD) + 1;
  localparam int PULSE_W = $clog2(PULSE_LEN) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  // ---------------- IRQ0 tick ----------------
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic              irq0_reg;

  always_comb begin
    tick_cnt_next = (tick_cnt_reg == TICK_W'(TICK_PERIOD - 1)) ? '0 : tick_cnt_reg + 1'b1;
  end

  // Output is computed from the next count so it is high exactly while the count sits in the window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt_reg <= '0;
      irq0_reg     <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      irq0_reg     <= (tick_cnt_next >= TICK_W'(TICK_PERIOD - TICK_HIGH));
    end
  end

  assign bus.out_node_IRQ0 = irq0_reg;

  // ---------------- opcode decode and priorities ----------------
  logic [N_NODES-1:0]             raise_vld;
  logic [N_NODES-1:0][3:0]        raise_tgt;
  logic [N_NODES-1:0][PRIO_W-1:0] prio;
  logic [N_NODES-1:0]             raise_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_NODES; gi++) begin : g_node
      logic [15:0]       op_word;
      logic              set_prio;
      logic [PRIO_W-1:0] prio_reg;

      assign op_word       = bus.in_op_node[gi*OP_W +: 16];
      assign set_prio      = bus.op_valid[gi] && ((op_word & 16'h3FF0) == 16'h2F10);
      assign raise_vld[gi] = bus.op_valid[gi] && (op_word[15:4] == 12'h3F1) &&
                             (op_word[3:0] != 4'd0) && (op_word[3:0] <= 4'(N_NODES));
      assign raise_tgt[gi] = op_word[3:0];

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)        prio_reg <= PRIO_W'(PRIO_RST);
        else if (set_prio) prio_reg <= op_word[PRIO_W-1:0];
      end

      assign prio[gi] = prio_reg;
    end
  endgenerate

  // Several raisers targeting the same node in one cycle collapse into a single event.
  always_comb begin
    raise_hit = '0;
    for (int j = 0; j < N_NODES; j++)
      for (int i = 0; i < N_NODES; i++)
        if (raise_vld[i] && (raise_tgt[i] == 4'(j + 1))) raise_hit[j] = 1'b1;
  end

  // ---------------- IRQ1 ext synchroniser and arbiter ----------------
  logic sync1_reg, sync2_reg, sync3_reg, edge_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      edge_reg  <= 1'b0;
    end else begin
      sync1_reg <= bus.ext_signal;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      edge_reg  <= sync2_reg & ~sync3_reg;
    end
  end

  // Strict '>' keeps the lowest index on ties and leaves priority-0 nodes ineligible.
  logic [PRIO_W-1:0]  best_prio;
  logic [N_NODES-1:0] arb_grant;
  logic               arb_ok;

  always_comb begin
    best_prio = '0;
    arb_grant = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (prio[i] > best_prio) begin
        best_prio    = prio[i];
        arb_grant    = '0;
        arb_grant[i] = 1'b1;
      end
    end
  end

  assign arb_ok = |best_prio;

  state_t             state_reg;
  logic [N_NODES-1:0] grant_reg;
  logic [PULSE_W-1:0] gcnt_reg;
  logic               ext_pend_reg;
  logic               overrun_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      gcnt_reg     <= '0;
      ext_pend_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ext_pend_reg || edge_reg) begin
            if (arb_ok) begin
              state_reg <= GRANT;
              grant_reg <= arb_grant;
              gcnt_reg  <= '0;
            end else begin
              overrun_reg <= 1'b1;
            end
            // A fresh edge arriving while a queued one is serviced becomes the next pending event.
            ext_pend_reg <= ext_pend_reg && edge_reg && arb_ok;
          end
        end
        GRANT: begin
          if (edge_reg) begin
            if (ext_pend_reg) overrun_reg  <= 1'b1;
            else              ext_pend_reg <= 1'b1;
          end
          if (gcnt_reg == PULSE_W'(PULSE_LEN - 1)) begin
            state_reg <= IDLE;
            grant_reg <= '0;
          end else begin
            gcnt_reg <= gcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_mutex_IRQ1 = grant_reg;
  assign bus.ext_overrun    = overrun_reg;

  // ---------------- IRQ2 per-node pulses ----------------
  generate
    for (gi = 0; gi < N_NODES; gi++) begin : g_irq2
      logic               irq2_reg;
      logic               pend_reg;
      logic [PULSE_W-1:0] cnt_reg;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          irq2_reg <= 1'b0;
          pend_reg <= 1'b0;
          cnt_reg  <= '0;
        end else if (irq2_reg) begin
          if (raise_hit[gi]) pend_reg <= 1'b1;
          if (cnt_reg == PULSE_W'(PULSE_LEN - 1)) irq2_reg <= 1'b0;
          else                                    cnt_reg  <= cnt_reg + 1'b1;
        end else if (pend_reg || raise_hit[gi]) begin
          irq2_reg <= 1'b1;
          cnt_reg  <= '0;
          pend_reg <= 1'b0;
        end
      end

      assign bus.out_IRQ2[gi] = irq2_reg;
    end
  endgenerate

endmodule

// File: tb/tb_espic_arbiter_n.sv
// Directed bench for espic_arbiter_n: tick window, IRQ1 arbitration/queueing/overrun,
// IRQ2 pulses with merge and re-pulse, and asynchronous reset mid-activity.
module tb_espic_arbiter_n;
  localparam int N   = 2;
  localparam int OPW = 16;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  espic_arbiter_n_if #(.N_NODES(N), .OP_W(OPW)) bus ();

  espic_arbiter_n #(
    .N_NODES(N), .OP_W(OPW), .PRIO_W(4), .PRIO_RST(1),
    .PULSE_LEN(8), .TICK_PERIOD(20), .TICK_HIGH(2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_op(input int node, input logic [15:0] op);
    bus.in_op_node[node*OPW +: OPW] = op;
    bus.op_valid[node]              = 1'b1;
    $display("[%0t] op node%0d = %h", $time, node, op);
  endtask

  task automatic clr_op();
    bus.op_valid   = '0;
    bus.in_op_node = '0;
  endtask

  task automatic send_op(input int node, input logic [15:0] op);
    set_op(node, op);
    cyc(1);
    clr_op();
  endtask

  task automatic ext_pulse();
    $display("[%0t] ext pulse", $time);
    bus.ext_signal = 1'b1;
    cyc(1);
    bus.ext_signal = 1'b0;
  endtask

  // Called right after ext_pulse: grant appears on the 3rd edge and lasts 8 cycles.
  task automatic expect_grant(input string tag, input logic [1:0] exp);
    cyc(2);
    check_eq({tag, "_pre"}, 32'(bus.out_mutex_IRQ1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check_eq({tag, "_hold"}, 32'(bus.out_mutex_IRQ1), 32'(exp));
    end
    cyc(1);
    check_eq({tag, "_end"}, 32'(bus.out_mutex_IRQ1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_m;
    logic [1:0] exp_i;

    bus.ext_signal = 1'b0;
    clr_op();
    cyc(2);
    check_eq("rst_irq0", 32'(bus.out_node_IRQ0), 32'd0);
    check_eq("rst_irq1", 32'(bus.out_mutex_IRQ1), 32'd0);
    check_eq("rst_irq2", 32'(bus.out_IRQ2), 32'd0);
    check_eq("rst_ovr", 32'(bus.ext_overrun), 32'd0);

    // 1: tick window on counts 18-19
    RST_N = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc(1);
      check_eq("t1_irq0", 32'(bus.out_node_IRQ0), 32'((k % 20) >= 18));
      check_eq("t1_quiet", 32'({bus.out_mutex_IRQ1, bus.out_IRQ2, bus.ext_overrun}), 32'd0);
    end
    $display("[%0t] tick window checked", $time);

    // 2: tie at reset priorities goes to node0, then node1 with prio 4
    cyc(2);
    ext_pulse();
    expect_grant("t2_tie", 2'b01);
    send_op(1, 16'h2F14);
    ext_pulse();
    expect_grant("t2_prio", 2'b10);

    // 3a: all priorities 0 -> overrun, no grant
    set_op(0, 16'h2F10);
    set_op(1, 16'h2F10);
    cyc(1);
    clr_op();
    ext_pulse();
    cyc(2);
    check_eq("t3_ovr_pre", 32'(bus.ext_overrun), 32'd0);
    cyc(1);
    check_eq("t3_ovr", 32'(bus.ext_overrun), 32'd1);
    check_eq("t3_nogrant", 32'(bus.out_mutex_IRQ1), 32'd0);
    cyc(1);
    check_eq("t3_ovr_end", 32'(bus.ext_overrun), 32'd0);
    for (int t = 0; t < 8; t++) begin
      cyc(1);
      check_eq("t3_nogrant", 32'(bus.out_mutex_IRQ1), 32'd0);
    end

    // 3b: queued edge plus overrun, re-grant uses priorities written mid-grant
    set_op(0, 16'h2F13);
    set_op(1, 16'h2F12);
    cyc(1);
    clr_op();
    ext_pulse();
    cyc(3);
    check_eq("t3_g1", 32'(bus.out_mutex_IRQ1), 32'd1);
    bus.ext_signal = 1'b1;
    cyc(1);
    bus.ext_signal = 1'b0;
    cyc(1);
    bus.ext_signal = 1'b1;
    cyc(1);
    bus.ext_signal = 1'b0;
    set_op(1, 16'h2F15);
    for (int t = 7; t <= 21; t++) begin
      cyc(1);
      if (t == 7) clr_op();
      exp_m = (t <= 10) ? 2'b01 : (t == 11) ? 2'b00 : (t <= 19) ? 2'b10 : 2'b00;
      check_eq("t3_queue_grant", 32'(bus.out_mutex_IRQ1), 32'(exp_m));
      check_eq("t3_queue_ovr", 32'(bus.ext_overrun), 32'(t == 9));
    end

    // 4: IRQ2 to node1, re-raise mid-pulse, out-of-range target ignored
    cyc(3);
    set_op(0, 16'h3F12);
    for (int t = 1; t <= 20; t++) begin
      cyc(1);
      if (t == 1 || t == 6 || t == 13) clr_op();
      exp_i = ((t <= 8) || (t >= 10 && t <= 17)) ? 2'b10 : 2'b00;
      check_eq("t4_irq2", 32'(bus.out_IRQ2), 32'(exp_i));
      if (t == 5)  set_op(1, 16'h3F12);
      if (t == 12) set_op(0, 16'h3F13);
    end

    // 5: simultaneous raise of node0 from both nodes -> one pulse
    set_op(0, 16'h3F11);
    set_op(1, 16'h3F11);
    for (int t = 1; t <= 12; t++) begin
      cyc(1);
      if (t == 1) clr_op();
      check_eq("t5_irq2", 32'(bus.out_IRQ2), 32'((t <= 8) ? 2'b01 : 2'b00));
    end

    // 6: async reset mid-grant with queued edge and mid-IRQ2
    ext_pulse();
    cyc(3);
    check_eq("t6_grant", 32'(bus.out_mutex_IRQ1), 32'd2);
    bus.ext_signal = 1'b1;
    cyc(1);
    bus.ext_signal = 1'b0;
    set_op(0, 16'h3F11);
    cyc(1);
    clr_op();
    cyc(3);
    check_eq("t6_grant_mid", 32'(bus.out_mutex_IRQ1), 32'd2);
    check_eq("t6_irq2_mid", 32'(bus.out_IRQ2), 32'd1);
    $display("[%0t] reset asserted", $time);
    RST_N = 1'b0;
    #1;
    check_eq("t6_rst_irq1", 32'(bus.out_mutex_IRQ1), 32'd0);
    check_eq("t6_rst_irq2", 32'(bus.out_IRQ2), 32'd0);
    check_eq("t6_rst_irq0", 32'(bus.out_node_IRQ0), 32'd0);
    check_eq("t6_rst_ovr", 32'(bus.ext_overrun), 32'd0);
    cyc(2);
    RST_N = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      cyc(1);
      check_eq("t6_no_replay", 32'({bus.out_mutex_IRQ1, bus.out_IRQ2, bus.ext_overrun}), 32'd0);
      check_eq("t6_irq0", 32'(bus.out_node_IRQ0), 32'd0);
    end
    ext_pulse();
    expect_grant("t6_prio_rst", 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
